// File: rtl/rans_pkg.sv
// Shared constants and width helpers for the rANS decoder datapath.
package rans_pkg;

  localparam int RANS_DATA_W = 8;
  localparam int RANS_CNT_W  = 24;

  // Index width for selecting one of 'lanes' lanes (at least 1 bit).
  function automatic int lane_idx_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // Read/write pointer width for a buffer of 'depth' entries (at least 1 bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rans_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy.
// Head reads as zero while empty so the output bus is clean after reset.
module rans_sync_fifo
  import rans_pkg::*;
#(
  parameter int DATA_W = RANS_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   full,
  output logic                   empty,
  output logic [ptr_w(DEPTH):0]  count
);

  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; a full FIFO refuses pushes even when popping.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Control state: cleared by reset or flush.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array: data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rans_lane_collector.sv
// Round-robin merge of interleaved rANS lane outputs back into plaintext order,
// buffered through a FIFO onto a valid/ready byte stream with length tracking.
module rans_lane_collector
  import rans_pkg::*;
#(
  parameter int LANES      = 2,
  parameter int DATA_W     = RANS_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = RANS_CNT_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    restart,
  input  logic [CNT_W-1:0]        expected_len,
  input  logic [LANES-1:0]        lane_valid,
  input  logic [LANES*DATA_W-1:0] lane_data,
  output logic [LANES-1:0]        lane_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        byte_count,
  output logic                    done
);

  localparam int LIW = lane_idx_w(LANES);
  localparam int PW  = ptr_w(FIFO_DEPTH);

  logic [LIW-1:0]    lane_ptr_q, lane_ptr_d;
  logic [CNT_W-1:0]  in_count_q, in_count_d;
  logic [CNT_W-1:0]  byte_count_q, byte_count_d;
  logic [CNT_W-1:0]  byte_inc;
  logic              done_q, done_d;

  logic              sel_valid;
  logic [DATA_W-1:0] sel_data;
  logic              in_done;
  logic              accept_en;
  logic              push, pop;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [PW:0]       fifo_count;

  // Stop accepting once the expected plaintext length has been taken in.
  assign in_done   = (expected_len != '0) && (in_count_q == expected_len);
  // Acceptance depends only on registered state (plus reset), never on out_ready or lane_valid.
  assign accept_en = resetn & ~fifo_full & ~in_done;
  assign push      = sel_valid & accept_en;
  assign pop       = out_ready & (fifo_count != '0);

  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_dout;
  assign byte_count = byte_count_q;
  assign done       = done_q;

  // Select the lane currently owed the next plaintext byte and grant only that lane.
  always_comb begin
    sel_valid  = 1'b0;
    sel_data   = '0;
    lane_ready = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_ptr_q == LIW'(k)) begin
        sel_valid     = lane_valid[k];
        sel_data      = lane_data[k*DATA_W +: DATA_W];
        lane_ready[k] = accept_en;
      end
    end
  end

  // Next-state for lane pointer, counters and sticky done flag.
  always_comb begin
    lane_ptr_d   = lane_ptr_q;
    in_count_d   = in_count_q;
    byte_count_d = byte_count_q;
    done_d       = done_q;
    byte_inc     = byte_count_q + CNT_W'(1);
    if (push) begin
      lane_ptr_d = (lane_ptr_q == LIW'(LANES-1)) ? '0 : lane_ptr_q + LIW'(1);
      in_count_d = in_count_q + CNT_W'(1);
    end
    if (pop) begin
      byte_count_d = byte_inc;
      if ((expected_len != '0) && (byte_inc == expected_len)) done_d = 1'b1;
    end
  end

  // Control registers; restart acts exactly like reset and overrides any handshake.
  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      lane_ptr_q   <= '0;
      in_count_q   <= '0;
      byte_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      lane_ptr_q   <= lane_ptr_d;
      in_count_q   <= in_count_d;
      byte_count_q <= byte_count_d;
      done_q       <= done_d;
    end
  end

  rans_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (restart),
    .push   (push),
    .pop    (pop),
    .din    (sel_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_rans_lane_collector.sv
// Directed bench for rans_lane_collector: main instance (LANES=2, depth 16, 24-bit
// counters) plus a narrow-counter instance (CNT_W=4) for wrap behaviour.
module tb_rans_lane_collector;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, restart, out_ready, done, out_valid;
  logic [23:0] expected_len, byte_count;
  logic [1:0]  lane_valid, lane_ready;
  logic [15:0] lane_data;
  logic [7:0]  out_data;

  logic        w_restart, w_out_ready, w_done, w_out_valid;
  logic [3:0]  w_expected_len, w_byte_count;
  logic [1:0]  w_lane_valid, w_lane_ready;
  logic [15:0] w_lane_data;
  logic [7:0]  w_out_data;

  rans_lane_collector #(.LANES(2), .DATA_W(8), .FIFO_DEPTH(16), .CNT_W(24)) dut (
    .clk(clk), .resetn(resetn), .restart(restart), .expected_len(expected_len),
    .lane_valid(lane_valid), .lane_data(lane_data), .lane_ready(lane_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .byte_count(byte_count), .done(done)
  );

  rans_lane_collector #(.LANES(2), .DATA_W(8), .FIFO_DEPTH(16), .CNT_W(4)) dut_w (
    .clk(clk), .resetn(resetn), .restart(w_restart), .expected_len(w_expected_len),
    .lane_valid(w_lane_valid), .lane_data(w_lane_data), .lane_ready(w_lane_ready),
    .out_valid(w_out_valid), .out_data(w_out_data), .out_ready(w_out_ready),
    .byte_count(w_byte_count), .done(w_done)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] lq0[$];
  logic [7:0] lq1[$];
  logic [7:0] expq[$];
  bit         lanes_en;
  int         push_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    lane_valid[0]   = lanes_en && (lq0.size() > 0);
    lane_data[7:0]  = (lq0.size() > 0) ? lq0[0] : 8'h00;
    lane_valid[1]   = lanes_en && (lq1.size() > 0);
    lane_data[15:8] = (lq1.size() > 0) ? lq1[0] : 8'h00;
  endtask

  // One clock: capture handshakes before the edge, apply them after it.
  task automatic step();
    logic [1:0] hs;
    logic       pv;
    logic [7:0] pd;
    hs = lane_valid & lane_ready;
    pv = out_valid & out_ready;
    pd = out_data;
    @(posedge clk); #1;
    if (hs[0]) void'(lq0.pop_front());
    if (hs[1]) void'(lq1.pop_front());
    push_cnt += $countones(hs);
    if (pv) begin
      if (expq.size() == 0) chk("pop_expected", 32'(expq.size() != 0), 32'd1);
      else                  chk("order", pd, expq.pop_front());
    end
    drive();
  endtask

  task automatic do_restart();
    restart   = 1'b1;
    lanes_en  = 1'b0;
    out_ready = 1'b0;
    drive();
    @(posedge clk); #1;
    restart = 1'b0;
    lq0.delete(); lq1.delete(); expq.delete();
    push_cnt = 0;
    drive();
  endtask

  initial begin
    resetn = 1'b0; restart = 1'b0; expected_len = '0; out_ready = 1'b0;
    lanes_en = 1'b0; push_cnt = 0;
    w_restart = 1'b0; w_expected_len = '0; w_out_ready = 1'b0;
    w_lane_valid = '0; w_lane_data = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid",  out_valid, 0);
    chk("rst_out_data",   out_data, 0);
    chk("rst_done",       done, 0);
    chk("rst_lane_ready", lane_ready, 0);
    chk("rst_byte_count", byte_count, 0);
    chk("rst_w_count",    w_byte_count, 0);

    // Test 1: "HEl" on lane0, "lo!" on lane1, length 6
    expected_len = 24'd6;
    lq0 = '{8'h48, 8'h45, 8'h6C};
    lq1 = '{8'h6C, 8'h6F, 8'h21};
    expq = '{8'h48, 8'h6C, 8'h45, 8'h6F, 8'h6C, 8'h21};
    out_ready = 1'b1; lanes_en = 1'b1; drive();
    resetn = 1'b1;
    #1;
    chk("t1_ready0", lane_ready, 2'b01);
    step();
    chk("t1_lat_valid", out_valid, 1);
    chk("t1_lat_data",  out_data, 8'h48);
    for (int i = 0; i < 40 && !done; i++) begin
      if (expq.size() == 1 && out_valid) chk("t1_done_pre", done, 0);
      step();
    end
    chk("t1_done",       done, 1);
    chk("t1_byte_count", byte_count, 6);
    chk("t1_all_out",    expq.size(), 0);
    chk("t1_ready_off",  lane_ready, 2'b00);
    chk("t1_valid_off",  out_valid, 0);
    repeat (3) step();
    chk("t1_done_hold",  done, 1);

    // Test 2: only lane1 valid -> held off until lane0 presents
    expected_len = '0;
    do_restart();
    chk("t2_done_clr", done, 0);
    chk("t2_cnt_clr",  byte_count, 0);
    lq1.push_back(8'h41);
    lanes_en = 1'b1; out_ready = 1'b1; drive();
    for (int i = 0; i < 5; i++) begin
      chk("t2_no_ready1", lane_ready[1], 0);
      step();
      chk("t2_idle", out_valid, 0);
    end
    lq0.push_back(8'h42);
    expq = '{8'h42, 8'h41};
    drive();
    for (int i = 0; i < 10 && expq.size() > 0; i++) step();
    chk("t2_all_out", expq.size(), 0);
    chk("t2_count",   byte_count, 2);

    // Test 3: fill to full with out_ready low, then single pop frees one slot
    do_restart();
    for (int i = 0; i < 10; i++) begin
      lq0.push_back(8'(i));
      lq1.push_back(8'(8'h80 + i));
      expq.push_back(8'(i));
      expq.push_back(8'(8'h80 + i));
    end
    lanes_en = 1'b1; drive();
    repeat (18) step();
    chk("t3_pushes16",  push_cnt, 16);
    chk("t3_full_rdy",  lane_ready, 2'b00);
    chk("t3_valid",     out_valid, 1);
    chk("t3_head",      out_data, 8'h00);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_rdy_after_pop", lane_ready, 2'b01);
    chk("t3_no_push_yet",   push_cnt, 16);
    step();
    chk("t3_push17",    push_cnt, 17);
    chk("t3_full_again", lane_ready, 2'b00);
    out_ready = 1'b1;
    for (int i = 0; i < 80 && expq.size() > 0; i++) step();
    chk("t3_all_out", expq.size(), 0);
    chk("t3_count",   byte_count, 20);

    // Test 4: steady push+pop at occupancy 5
    do_restart();
    for (int i = 0; i < 8; i++) begin
      lq0.push_back(8'(8'h10 + i));
      expq.push_back(8'(8'h10 + i));
      if (i < 7) begin
        lq1.push_back(8'(8'h20 + i));
        expq.push_back(8'(8'h20 + i));
      end
    end
    lanes_en = 1'b1; drive();
    for (int i = 0; i < 20 && push_cnt < 5; i++) step();
    chk("t4_occ_start", dut.u_fifo.count, 5);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t4_occ", dut.u_fifo.count, 5);
    end
    chk("t4_count10", byte_count, 10);
    for (int i = 0; i < 20 && expq.size() > 0; i++) step();
    chk("t4_all_out", expq.size(), 0);
    chk("t4_count15", byte_count, 15);

    // Test 5: restart with a same-cycle push at in_count=3
    expected_len = 24'd10;
    do_restart();
    lq0 = '{8'h61, 8'h63, 8'h65};
    lq1 = '{8'h62, 8'h64, 8'h66};
    lanes_en = 1'b1; drive();
    for (int i = 0; i < 20 && push_cnt < 3; i++) step();
    chk("t5_pending", lane_ready & lane_valid, 2'b10);
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("t5_valid",   out_valid, 0);
    chk("t5_count",   byte_count, 0);
    chk("t5_done",    done, 0);
    chk("t5_ptr",     dut.lane_ptr_q, 0);
    chk("t5_incount", dut.in_count_q, 0);
    lq0 = '{8'h61, 8'h63, 8'h65};
    lq1 = '{8'h62, 8'h64, 8'h66};
    expq = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    expected_len = 24'd6;
    out_ready = 1'b1; drive();
    for (int i = 0; i < 40 && !done; i++) step();
    chk("t5_done_after", done, 1);
    chk("t5_count6",     byte_count, 6);
    chk("t5_all_out",    expq.size(), 0);

    // Test 6: unbounded length on 4-bit counters, 20 bytes
    begin : t6
      int         wi0, wi1, wpops;
      bit         seen_done;
      logic [1:0] hs;
      logic       pv;
      logic [7:0] pd;
      wi0 = 0; wi1 = 0; wpops = 0; seen_done = 1'b0;
      w_out_ready = 1'b1;
      for (int c = 0; c < 100 && wpops < 20; c++) begin
        w_lane_valid[0]   = (wi0 < 10);
        w_lane_data[7:0]  = 8'(2 * wi0);
        w_lane_valid[1]   = (wi1 < 10);
        w_lane_data[15:8] = 8'(2 * wi1 + 1);
        #1;
        hs = w_lane_valid & w_lane_ready;
        pv = w_out_valid & w_out_ready;
        pd = w_out_data;
        @(posedge clk); #1;
        if (hs[0]) wi0++;
        if (hs[1]) wi1++;
        if (w_done) seen_done = 1'b1;
        if (pv) begin
          chk("t6_order", pd, 32'(wpops));
          wpops++;
          if (wpops == 15 || wpops == 16 || wpops == 20)
            chk("t6_wrap", w_byte_count, 32'(wpops % 16));
        end
      end
      chk("t6_pops",    wpops, 20);
      chk("t6_no_done", seen_done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
